// File: rtl/ghost_mode_pkg.sv
// Shared definitions for the ghost mode scheduler: mode encoding, ghost
// indices and the scatter/chase phase table helpers.
package ghost_mode_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE    = 2'b00,
    MODE_SCATTER = 2'b01,
    MODE_CHASE   = 2'b10,
    MODE_FRIGHT  = 2'b11
  } mode_e;

  localparam int GHOST_RED    = 0;
  localparam int GHOST_BLUE   = 1;
  localparam int GHOST_ORANGE = 2;
  localparam int NUM_GHOSTS   = 3;

  // Phase 5 is the open-ended chase; its timer never runs.
  localparam logic [2:0] LAST_PHASE = 3'd5;

  function automatic mode_e phase_mode(input logic [2:0] phase_idx);
    return phase_idx[0] ? MODE_CHASE : MODE_SCATTER;
  endfunction

endpackage

// File: rtl/ghost_eat_arbiter.sv
// Collects caught ghosts into a pending mask and serves one bonus per cycle
// (red > blue > orange), doubling the bonus per catch up to 8x the base.
module ghost_eat_arbiter
  import ghost_mode_pkg::*;
#(
  parameter int BONUS_BASE = 10
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  clear,
  input  logic [NUM_GHOSTS-1:0] eat_hit,
  output logic [9:0]            score_to_reg,
  output logic                  Load_S
);

  logic [NUM_GHOSTS-1:0] pending_q, pending_d;
  logic [NUM_GHOSTS-1:0] cand, pick;
  logic [1:0]            eat_count_q, eat_count_d;
  logic [9:0]            score_d;
  logic                  load_d;

  // A fresh catch competes with older pending catches in the same cycle.
  always_comb begin
    cand = pending_q | eat_hit;
    pick = '0;
    if (cand[GHOST_RED])         pick[GHOST_RED]    = 1'b1;
    else if (cand[GHOST_BLUE])   pick[GHOST_BLUE]   = 1'b1;
    else if (cand[GHOST_ORANGE]) pick[GHOST_ORANGE] = 1'b1;
  end

  always_comb begin
    pending_d   = pending_q;
    eat_count_d = eat_count_q;
    score_d     = score_to_reg;
    load_d      = 1'b0;
    if (clear) begin
      pending_d   = '0;
      eat_count_d = '0;
    end else if (|cand) begin
      load_d    = 1'b1;
      score_d   = 10'(BONUS_BASE) << eat_count_q;
      pending_d = cand & ~pick;
      if (eat_count_q != 2'd3) eat_count_d = eat_count_q + 2'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pending_q    <= '0;
      eat_count_q  <= '0;
      score_to_reg <= '0;
      Load_S       <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      eat_count_q  <= eat_count_d;
      score_to_reg <= score_d;
      Load_S       <= load_d;
    end
  end

endmodule

// File: rtl/ghost_mode_scheduler.sv
// Frame-driven ghost mode sequencer: scatter/chase phase walk, frightened
// override with its own timer, and hand-off of catches to the bonus arbiter.
//
// state        | meaning
// MODE_IDLE    | game not started or just restarted / life lost
// MODE_SCATTER | even phase, main timer counting down
// MODE_CHASE   | odd phase, timed in 1/3, unlimited in phase 5
// MODE_FRIGHT  | power pellet active, main timer frozen, saved_q holds return mode
module ghost_mode_scheduler
  import ghost_mode_pkg::*;
#(
  parameter int SCATTER_FRAMES = 420,
  parameter int CHASE_FRAMES   = 1200,
  parameter int FRIGHT_FRAMES  = 360,
  parameter int FLASH_FRAMES   = 120,
  parameter int BONUS_BASE     = 10
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       run,
  input  logic       restart,
  input  logic       lifeDown,
  input  logic       power_pellet,
  input  logic [2:0] ghost_eaten,
  output logic [1:0] mode,
  output logic [2:0] ghost_fright,
  output logic       fright_flash,
  output logic       reverse,
  output logic [2:0] phase,
  output logic [9:0] score_to_reg,
  output logic       Load_S
);

  localparam int MAX_SC     = (SCATTER_FRAMES > CHASE_FRAMES) ? SCATTER_FRAMES : CHASE_FRAMES;
  localparam int MAX_FRAMES = (MAX_SC > FRIGHT_FRAMES) ? MAX_SC : FRIGHT_FRAMES;
  localparam int TW         = $clog2(MAX_FRAMES + 1);

  typedef logic [TW-1:0] timer_t;

  function automatic timer_t phase_len(input logic [2:0] phase_idx);
    return phase_idx[0] ? timer_t'(CHASE_FRAMES) : timer_t'(SCATTER_FRAMES);
  endfunction

  mode_e      mode_q, mode_d, saved_q, saved_d, base_mode;
  logic [2:0] phase_q, phase_d;
  timer_t     main_q, main_d, fright_q, fright_d;
  logic [2:0] gf_q, gf_d, eat_hit;
  logic       flash_q, flash_d, rev_q, rev_d;
  logic       arb_clear, eat_en, tick_run;

  assign tick_run = frame_tick & run;

  always_comb begin
    mode_d    = mode_q;
    saved_d   = saved_q;
    phase_d   = phase_q;
    main_d    = main_q;
    fright_d  = fright_q;
    gf_d      = gf_q;
    rev_d     = 1'b0;
    arb_clear = 1'b0;
    eat_en    = 1'b1;
    base_mode = mode_q;
    if (restart || lifeDown) begin
      mode_d    = MODE_IDLE;
      saved_d   = MODE_IDLE;
      phase_d   = '0;
      main_d    = '0;
      fright_d  = '0;
      gf_d      = '0;
      arb_clear = 1'b1;
      eat_en    = 1'b0;
    end else begin
      case (mode_q)
        MODE_IDLE: begin
          if (run) begin
            mode_d  = MODE_SCATTER;
            phase_d = '0;
            main_d  = phase_len(3'd0);
          end
        end
        MODE_SCATTER, MODE_CHASE: begin
          if (tick_run && phase_q != LAST_PHASE) begin
            if (main_q <= timer_t'(1)) begin
              phase_d   = phase_q + 3'd1;
              main_d    = phase_len(phase_d);
              base_mode = phase_mode(phase_d);
              rev_d     = 1'b1;
            end else begin
              main_d = main_q - timer_t'(1);
            end
          end
          mode_d = base_mode;
          // A pellet landing on a phase boundary returns to the new phase.
          if (power_pellet) begin
            saved_d   = base_mode;
            mode_d    = MODE_FRIGHT;
            fright_d  = timer_t'(FRIGHT_FRAMES);
            gf_d      = '1;
            rev_d     = 1'b1;
            arb_clear = 1'b1;
            eat_en    = 1'b0;
          end
        end
        MODE_FRIGHT: begin
          if (power_pellet) begin
            fright_d  = timer_t'(FRIGHT_FRAMES);
            gf_d      = '1;
            arb_clear = 1'b1;
            eat_en    = 1'b0;
          end else if (tick_run && fright_q <= timer_t'(1)) begin
            mode_d    = saved_q;
            fright_d  = '0;
            gf_d      = '0;
            arb_clear = 1'b1;
            eat_en    = 1'b0;
          end else if (tick_run) begin
            fright_d = fright_q - timer_t'(1);
          end
        end
        default: ;
      endcase
    end
    eat_hit = eat_en ? (ghost_eaten & gf_q) : 3'b000;
    gf_d    = gf_d & ~eat_hit;
    flash_d = (mode_d == MODE_FRIGHT) && (fright_d <= timer_t'(FLASH_FRAMES));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mode_q   <= MODE_IDLE;
      saved_q  <= MODE_IDLE;
      phase_q  <= '0;
      main_q   <= '0;
      fright_q <= '0;
      gf_q     <= '0;
      flash_q  <= 1'b0;
      rev_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      saved_q  <= saved_d;
      phase_q  <= phase_d;
      main_q   <= main_d;
      fright_q <= fright_d;
      gf_q     <= gf_d;
      flash_q  <= flash_d;
      rev_q    <= rev_d;
    end
  end

  ghost_eat_arbiter #(
    .BONUS_BASE(BONUS_BASE)
  ) u_eat_arbiter (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .clear       (arb_clear),
    .eat_hit     (eat_hit),
    .score_to_reg(score_to_reg),
    .Load_S      (Load_S)
  );

  assign mode         = mode_q;
  assign phase        = phase_q;
  assign ghost_fright = gf_q;
  assign fright_flash = flash_q;
  assign reverse      = rev_q;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Bench for ghost_mode_scheduler: directed scenarios with spec-derived
// constants, then a randomized run against a frame-counting reference model.
module tb_ghost_mode_scheduler;

  localparam int S  = 4;
  localparam int C  = 6;
  localparam int F  = 5;
  localparam int FL = 2;
  localparam int B  = 10;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0, run = 1'b0, restart = 1'b0, lifeDown = 1'b0, power_pellet = 1'b0;
  logic [2:0] ghost_eaten = 3'b000;
  logic [1:0] mode;
  logic [2:0] ghost_fright, phase;
  logic       fright_flash, reverse, Load_S;
  logic [9:0] score_to_reg;

  int errors = 0;
  int checks = 0;

  ghost_mode_scheduler #(
    .SCATTER_FRAMES(S), .CHASE_FRAMES(C), .FRIGHT_FRAMES(F),
    .FLASH_FRAMES(FL), .BONUS_BASE(B)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .run(run),
    .restart(restart), .lifeDown(lifeDown), .power_pellet(power_pellet),
    .ghost_eaten(ghost_eaten), .mode(mode), .ghost_fright(ghost_fright),
    .fright_flash(fright_flash), .reverse(reverse), .phase(phase),
    .score_to_reg(score_to_reg), .Load_S(Load_S)
  );

  always #5 Clk = ~Clk;

  // Reference model: 0 idle, 1 scatter, 2 chase, 3 frightened; phase progress
  // is counted upward in frames, caught ghosts wait in a queue of indices.
  int     m_mode, m_phase, m_elapsed, m_fleft, m_saved, m_cnt, m_score;
  bit [2:0] m_gf;
  bit     m_rev, m_load, m_flash;
  int     m_pend[$];

  function automatic void model_reset();
    m_mode = 0; m_phase = 0; m_elapsed = 0; m_fleft = 0; m_saved = 0; m_cnt = 0;
    m_gf = 3'b000; m_rev = 0; m_load = 0; m_flash = 0;
    m_pend.delete();
  endfunction

  function automatic void model_step(bit r, bit t, bit pp, bit [2:0] ge, bit kill);
    bit [2:0] hits;
    bit clr;
    int nm;
    hits = 3'b000; clr = 0; m_rev = 0; m_load = 0;
    if (kill) begin
      model_reset();
      return;
    end
    if (m_mode == 0) begin
      if (r) begin m_mode = 1; m_phase = 0; m_elapsed = 0; end
    end else if (m_mode == 3) begin
      if (pp) begin
        m_fleft = F; m_gf = 3'b111; clr = 1;
      end else if (r && t && m_fleft == 1) begin
        m_mode = m_saved; m_gf = 3'b000; m_fleft = 0; clr = 1;
      end else begin
        if (r && t) m_fleft--;
        hits = ge & m_gf;
      end
    end else begin
      nm = m_mode;
      if (r && t && m_phase != 5) begin
        m_elapsed++;
        if (m_elapsed == ((m_phase % 2) ? C : S)) begin
          m_phase++; m_elapsed = 0; nm = (m_phase % 2) ? 2 : 1; m_rev = 1;
        end
      end
      if (pp) begin
        m_saved = nm; m_mode = 3; m_fleft = F; m_gf = 3'b111; clr = 1; m_rev = 1;
      end else begin
        m_mode = nm;
        hits = ge & m_gf;
      end
    end
    m_gf &= ~hits;
    for (int i = 0; i < 3; i++) if (hits[i]) m_pend.push_back(i);
    if (clr) begin
      m_pend.delete(); m_cnt = 0;
    end else if (m_pend.size() > 0) begin
      m_pend.sort();
      void'(m_pend.pop_front());
      m_load = 1;
      m_score = B * (1 << m_cnt);
      if (m_cnt < 3) m_cnt++;
    end
    m_flash = (m_mode == 3) && (m_fleft <= FL);
  endfunction

  task automatic step(bit r, bit t, bit pp = 0, bit [2:0] ge = 3'b000, bit kl = 0, bit rs = 0);
    run = r; frame_tick = t; power_pellet = pp; ghost_eaten = ge; lifeDown = kl; restart = rs;
    @(posedge Clk); #1;
    model_step(r, t, pp, ge, kl | rs);
    frame_tick = 0; power_pellet = 0; ghost_eaten = 3'b000; lifeDown = 0; restart = 0;
  endtask

  task automatic start();
    step(0, 0, 0, 3'b000, 0, 1);
    step(1, 0);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({mode, phase, ghost_fright} !== 8'd0) begin
      errors++; $display("FAIL reset_mode_phase_fright: got %0d/%0d/%0d expected 0/0/0", mode, phase, ghost_fright);
    end
    checks++;
    if ({fright_flash, reverse, Load_S, score_to_reg} !== 13'd0) begin
      errors++; $display("FAIL reset_flags_score: got flash=%0d rev=%0d load=%0d score=%0d expected all 0", fright_flash, reverse, Load_S, score_to_reg);
    end
    #5 Reset_n = 1'b1;
    model_reset();
    step(0, 1);
    checks++;
    if (mode !== 2'd0) begin errors++; $display("FAIL idle_without_run: got mode %0d expected 0", mode); end
  endtask

  task automatic test_phase_walk();
    int revs;
    start();
    checks++;
    if ({mode, phase} !== {2'd1, 3'd0}) begin errors++; $display("FAIL walk_enter: got mode %0d phase %0d expected 1/0", mode, phase); end
    repeat (3) step(1, 1);
    checks++;
    if (mode !== 2'd1) begin errors++; $display("FAIL walk_tick3: got mode %0d expected 1", mode); end
    step(1, 1);
    checks++;
    if ({mode, phase, reverse} !== {2'd2, 3'd1, 1'b1}) begin
      errors++; $display("FAIL walk_ph1: got mode %0d phase %0d rev %0d expected 2/1/1", mode, phase, reverse);
    end
    step(1, 0);
    checks++;
    if (reverse !== 1'b0) begin errors++; $display("FAIL walk_rev_pulse: got %0d expected 0", reverse); end
    repeat (6) step(1, 1);
    checks++;
    if ({mode, phase} !== {2'd1, 3'd2}) begin errors++; $display("FAIL walk_ph2: got mode %0d phase %0d expected 1/2", mode, phase); end
    repeat (4) step(1, 1);
    repeat (6) step(1, 1);
    repeat (4) step(1, 1);
    checks++;
    if ({mode, phase} !== {2'd2, 3'd5}) begin errors++; $display("FAIL walk_ph5: got mode %0d phase %0d expected 2/5", mode, phase); end
    revs = 0;
    repeat (100) begin
      step(1, 1);
      if (reverse) revs++;
    end
    checks++;
    if ({mode, phase} !== {2'd2, 3'd5} || revs != 0) begin
      errors++; $display("FAIL walk_ph5_hold: got mode %0d phase %0d revs %0d expected 2/5/0", mode, phase, revs);
    end
  endtask

  task automatic test_fright();
    start();
    repeat (2) step(1, 1);
    step(1, 0, 1);
    checks++;
    if ({mode, ghost_fright, reverse} !== {2'd3, 3'b111, 1'b1}) begin
      errors++; $display("FAIL fright_enter: got mode %0d fright %0d rev %0d expected 3/7/1", mode, ghost_fright, reverse);
    end
    step(1, 0);
    checks++;
    if (reverse !== 1'b0) begin errors++; $display("FAIL fright_single_rev: got %0d expected 0", reverse); end
    repeat (2) step(1, 1);
    checks++;
    if (fright_flash !== 1'b0) begin errors++; $display("FAIL flash_early: got %0d expected 0", fright_flash); end
    step(1, 1);
    checks++;
    if (fright_flash !== 1'b1) begin errors++; $display("FAIL flash_rise: got %0d expected 1", fright_flash); end
    repeat (2) step(1, 1);
    checks++;
    if ({mode, ghost_fright, fright_flash, reverse} !== {2'd1, 3'b000, 1'b0, 1'b0}) begin
      errors++; $display("FAIL fright_exit: got mode %0d fright %0d flash %0d rev %0d expected 1/0/0/0", mode, ghost_fright, fright_flash, reverse);
    end
    step(1, 1);
    checks++;
    if ({mode, phase} !== {2'd1, 3'd0}) begin errors++; $display("FAIL resume_scatter: got mode %0d phase %0d expected 1/0", mode, phase); end
    step(1, 1);
    checks++;
    if ({mode, phase} !== {2'd2, 3'd1}) begin errors++; $display("FAIL resume_expiry: got mode %0d phase %0d expected 2/1", mode, phase); end
  endtask

  task automatic test_arbitration();
    int exp3[3];
    exp3[0] = 10; exp3[1] = 20; exp3[2] = 40;
    start();
    step(1, 0, 1);
    step(1, 0, 0, 3'b111);
    checks++;
    if (ghost_fright !== 3'b000) begin errors++; $display("FAIL eat_clears_fright: got %0d expected 0", ghost_fright); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({Load_S, score_to_reg} !== {1'b1, 10'(exp3[i])}) begin
        errors++; $display("FAIL bonus_seq%0d: got load %0d score %0d expected 1/%0d", i, Load_S, score_to_reg, exp3[i]);
      end
      step(1, 0);
    end
    checks++;
    if (Load_S !== 1'b0) begin errors++; $display("FAIL bonus_seq_end: got load %0d expected 0", Load_S); end
    step(1, 0, 1);
    step(1, 0, 0, 3'b010);
    checks++;
    if ({Load_S, score_to_reg} !== {1'b1, 10'd10}) begin
      errors++; $display("FAIL new_pellet_resets_bonus: got load %0d score %0d expected 1/10", Load_S, score_to_reg);
    end
    step(1, 0, 1);
    step(1, 0, 0, 3'b110);
    checks++;
    if ({Load_S, score_to_reg} !== {1'b1, 10'd10}) begin
      errors++; $display("FAIL prio_first: got load %0d score %0d expected 1/10", Load_S, score_to_reg);
    end
    step(1, 0, 0, 3'b001);
    checks++;
    if ({Load_S, score_to_reg, ghost_fright} !== {1'b1, 10'd20, 3'b000}) begin
      errors++; $display("FAIL prio_red_late: got load %0d score %0d fright %0d expected 1/20/0", Load_S, score_to_reg, ghost_fright);
    end
    step(1, 0);
    checks++;
    if ({Load_S, score_to_reg} !== {1'b1, 10'd40}) begin
      errors++; $display("FAIL prio_orange_last: got load %0d score %0d expected 1/40", Load_S, score_to_reg);
    end
  endtask

  task automatic test_ignored();
    start();
    step(1, 0, 0, 3'b010);
    checks++;
    if (Load_S !== 1'b0) begin errors++; $display("FAIL eat_not_fright: got load %0d expected 0", Load_S); end
    step(0, 0, 0, 3'b000, 0, 1);
    step(0, 0, 1);
    checks++;
    if (mode !== 2'd0) begin errors++; $display("FAIL pellet_in_idle: got mode %0d expected 0", mode); end
    step(1, 0);
    repeat (10) step(0, 1);
    repeat (3) step(1, 1);
    checks++;
    if ({mode, phase} !== {2'd1, 3'd0}) begin errors++; $display("FAIL run_low_freeze: got mode %0d phase %0d expected 1/0", mode, phase); end
    step(1, 1);
    checks++;
    if ({mode, phase} !== {2'd2, 3'd1}) begin errors++; $display("FAIL run_low_resume: got mode %0d phase %0d expected 2/1", mode, phase); end
  endtask

  task automatic test_priority();
    start();
    repeat (3) step(1, 1);
    step(1, 1, 1, 3'b000, 1);
    checks++;
    if ({mode, phase, ghost_fright, reverse} !== {2'd0, 3'd0, 3'b000, 1'b0}) begin
      errors++; $display("FAIL lifedown_priority: got mode %0d phase %0d fright %0d rev %0d expected 0/0/0/0", mode, phase, ghost_fright, reverse);
    end
    start();
    repeat (3) step(1, 1);
    step(1, 1, 1);
    checks++;
    if ({mode, phase, reverse} !== {2'd3, 3'd1, 1'b1}) begin
      errors++; $display("FAIL pellet_at_expiry: got mode %0d phase %0d rev %0d expected 3/1/1", mode, phase, reverse);
    end
    step(1, 0);
    checks++;
    if (reverse !== 1'b0) begin errors++; $display("FAIL pellet_at_expiry_rev: got %0d expected 0", reverse); end
    repeat (5) step(1, 1);
    checks++;
    if ({mode, phase} !== {2'd2, 3'd1}) begin errors++; $display("FAIL saved_new_phase: got mode %0d phase %0d expected 2/1", mode, phase); end
    step(1, 0, 1);
    step(1, 0, 1, 3'b111);
    checks++;
    if ({Load_S, ghost_fright} !== {1'b0, 3'b111}) begin
      errors++; $display("FAIL pellet_beats_eat: got load %0d fright %0d expected 0/7", Load_S, ghost_fright);
    end
    repeat (4) step(1, 1);
    step(1, 1, 0, 3'b111);
    step(1, 0);
    checks++;
    if ({mode, ghost_fright, Load_S} !== {2'd2, 3'b000, 1'b0}) begin
      errors++; $display("FAIL expiry_beats_eat: got mode %0d fright %0d load %0d expected 2/0/0", mode, ghost_fright, Load_S);
    end
  endtask

  task automatic test_reset_mid_op();
    int loads;
    start();
    step(1, 0, 1);
    step(1, 0, 0, 3'b111);
    Reset_n = 1'b0;
    #2;
    checks++;
    if ({mode, phase, ghost_fright, fright_flash, reverse, Load_S, score_to_reg} !== 21'd0) begin
      errors++; $display("FAIL async_reset: got mode %0d fright %0d load %0d score %0d expected all 0", mode, ghost_fright, Load_S, score_to_reg);
    end
    model_reset();
    #1 Reset_n = 1'b1;
    loads = 0;
    repeat (4) begin
      step(0, 0);
      if (Load_S) loads++;
    end
    checks++;
    if (loads != 0 || mode !== 2'd0) begin errors++; $display("FAIL reset_drops_pending: got loads %0d mode %0d expected 0/0", loads, mode); end
  endtask

  task automatic test_random();
    bit r, t, pp, kl, rs;
    bit [2:0] ge;
    start();
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 9) != 0);
      t  = 1'($urandom_range(0, 1));
      pp = ($urandom_range(0, 24) == 0);
      ge = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      kl = ($urandom_range(0, 199) == 0);
      rs = ($urandom_range(0, 299) == 0);
      step(r, t, pp, ge, kl, rs);
      checks++;
      if (mode !== 2'(m_mode) || phase !== 3'(m_phase)) begin
        errors++; $display("FAIL rand_mode_phase cyc %0d: got %0d/%0d expected %0d/%0d", i, mode, phase, m_mode, m_phase);
      end
      checks++;
      if (ghost_fright !== m_gf || fright_flash !== m_flash || reverse !== m_rev) begin
        errors++; $display("FAIL rand_flags cyc %0d: got fright %0d flash %0d rev %0d expected %0d/%0d/%0d", i, ghost_fright, fright_flash, reverse, m_gf, m_flash, m_rev);
      end
      checks++;
      if (Load_S !== m_load || (m_load && score_to_reg !== 10'(m_score))) begin
        errors++; $display("FAIL rand_bonus cyc %0d: got load %0d score %0d expected %0d/%0d", i, Load_S, score_to_reg, m_load, m_score);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_phase_walk();
    test_fright();
    test_arbitration();
    test_ignored();
    test_priority();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
